issue_sequencer: RTL and testbench



---
 rtl/b32p_pkg.sv | 55 +++++
 rtl/reg_scoreboard.sv | 41 ++++
 rtl/issue_sequencer.sv | 105 ++++++++++
 tb/tb_issue_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/b32p_pkg.sv
// b32p_pkg: shared constants and helpers for the B32P issue sequencer.
// Opcode values, FSM state and stall-cause encodings, and the opcode
// classification functions used by the issue logic.
// Build option: ISSUE_FWD_EN -- EX->EX forwarding present, so only READ
// results are tracked in the scoreboard.
package b32p_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned NREGS   = 16;
  localparam int unsigned STALL_W = 2;

  localparam logic [OP_W-1:0] OP_ARITH  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ARITHC = 4'b0001;
  localparam logic [OP_W-1:0] OP_BRANCH = 4'b0110;
  localparam logic [OP_W-1:0] OP_LOAD   = 4'b0111;
  localparam logic [OP_W-1:0] OP_JUMP   = 4'b1001;
  localparam logic [OP_W-1:0] OP_JUMPR  = 4'b1010;
  localparam logic [OP_W-1:0] OP_WRITE  = 4'b1101;
  localparam logic [OP_W-1:0] OP_READ   = 4'b1110;
  localparam logic [OP_W-1:0] OP_HALT   = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_CTRL_WAIT = 2'd1,
    ST_HALTED    = 2'd2
  } state_e;

  typedef enum logic [STALL_W-1:0] {
    STALL_NONE = 2'd0,
    STALL_DATA = 2'd1,
    STALL_CTRL = 2'd2,
    STALL_MEM  = 2'd3
  } stall_e;

  // Opcode produces a result that later instructions must wait for.
  function automatic logic writes_dreg(input logic [OP_W-1:0] op);
`ifdef ISSUE_FWD_EN
    return op == OP_READ;
`else
    return op inside {OP_ARITH, OP_ARITHC, OP_LOAD, OP_READ};
`endif
  endfunction

  // Opcode consumes areg/breg.
  function automatic logic reads_src(input logic [OP_W-1:0] op);
    return !(op inside {OP_LOAD, OP_JUMP, OP_HALT});
  endfunction

  // Opcode redirects control flow and must be resolved before further issue.
  function automatic logic is_ctrl(input logic [OP_W-1:0] op);
    return op inside {OP_BRANCH, OP_JUMP, OP_JUMPR};
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write bit per architectural register.
// Ports: clk/resetn; set_en_i/set_reg_i mark a register pending on issue;
// clr_en_i/clr_reg_i clear it on writeback (set wins on collision);
// areg_i/breg_i/dreg_i lookups return combinational pending flags.
module reg_scoreboard
  import b32p_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             set_en_i,
  input  logic [REG_W-1:0] set_reg_i,
  input  logic             clr_en_i,
  input  logic [REG_W-1:0] clr_reg_i,
  input  logic [REG_W-1:0] areg_i,
  input  logic [REG_W-1:0] breg_i,
  input  logic [REG_W-1:0] dreg_i,
  output logic             a_pend_c_o,
  output logic             b_pend_c_o,
  output logic             d_pend_c_o
);

  logic [NREGS-1:0] sb_q, sb_d;

  // Clear first so a same-cycle set on the same register wins; r0 never pends.
  always_comb begin
    sb_d = sb_q;
    if (clr_en_i) sb_d[clr_reg_i] = 1'b0;
    if (set_en_i) sb_d[set_reg_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sb_q <= '0;
    else         sb_q <= sb_d;
  end

  assign a_pend_c_o = sb_q[areg_i];
  assign b_pend_c_o = sb_q[breg_i];
  assign d_pend_c_o = sb_q[dreg_i];

endmodule

// File: rtl/issue_sequencer.sv
// issue_sequencer: issue/hazard controller between ID and EX of B32P.
// Holds decoded instructions on RAW/WAW hazards, behind unresolved control
// flow, while memory is busy, and forever after HALT.
// Ports: id_* decoded instruction in, id_ready accept (comb), ex_issue
// registered issue strobe, mem_busy, br_resolved/br_taken from EX,
// wb_valid/wb_dreg writeback, flush (comb pulse), halted (sticky),
// stall_cause (comb, 0 when id_valid=0).
// Build option: ISSUE_FWD_EN (see b32p_pkg).
module issue_sequencer
  import b32p_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               id_valid,
  input  logic [OP_W-1:0]    id_instr_op,
  input  logic [REG_W-1:0]   id_areg,
  input  logic [REG_W-1:0]   id_breg,
  input  logic [REG_W-1:0]   id_dreg,
  output logic               id_ready,
  output logic               ex_issue,
  input  logic               mem_busy,
  input  logic               br_resolved,
  input  logic               br_taken,
  input  logic               wb_valid,
  input  logic [REG_W-1:0]   wb_dreg,
  output logic               flush,
  output logic               halted,
  output logic [STALL_W-1:0] stall_cause
);

  state_e state_q, state_d;
  logic   ex_issue_q;
  logic   a_pend_c, b_pend_c, d_pend_c;
  logic   writer_c, hazard_c, issue_c;

  reg_scoreboard u_sb (
    .clk        (clk),
    .resetn     (resetn),
    .set_en_i   (issue_c & writer_c),
    .set_reg_i  (id_dreg),
    .clr_en_i   (wb_valid),
    .clr_reg_i  (wb_dreg),
    .areg_i     (id_areg),
    .breg_i     (id_breg),
    .dreg_i     (id_dreg),
    .a_pend_c_o (a_pend_c),
    .b_pend_c_o (b_pend_c),
    .d_pend_c_o (d_pend_c)
  );

  // Hazard detection and issue handshake.
  always_comb begin
    writer_c = writes_dreg(id_instr_op) && (id_dreg != '0);
    hazard_c = (reads_src(id_instr_op) && (a_pend_c || b_pend_c))
             || (writer_c && d_pend_c);
    id_ready = (state_q == ST_RUN) && !mem_busy && !hazard_c;
    issue_c  = id_valid && id_ready;
  end

  // Next state and flush; resolves seen outside CTRL_WAIT are ignored.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (issue_c) begin
          if (id_instr_op == OP_HALT)   state_d = ST_HALTED;
          else if (is_ctrl(id_instr_op)) state_d = ST_CTRL_WAIT;
        end
      end
      ST_CTRL_WAIT: begin
        if (br_resolved) begin
          state_d = ST_RUN;
          flush   = br_taken;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Stall reason, highest priority first.
  always_comb begin
    stall_cause = STALL_NONE;
    if (id_valid) begin
      if (mem_busy || (state_q == ST_HALTED)) stall_cause = STALL_MEM;
      else if (state_q == ST_CTRL_WAIT)       stall_cause = STALL_CTRL;
      else if (hazard_c)                      stall_cause = STALL_DATA;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_RUN;
      ex_issue_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_issue_q <= issue_c;
    end
  end

  assign ex_issue = ex_issue_q;
  assign halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_issue_sequencer.sv
module tb_issue_sequencer;

  logic       clk, resetn;
  logic       id_valid;
  logic [3:0] id_instr_op, id_areg, id_breg, id_dreg;
  logic       id_ready, ex_issue;
  logic       mem_busy, br_resolved, br_taken;
  logic       wb_valid;
  logic [3:0] wb_dreg;
  logic       flush, halted;
  logic [1:0] stall_cause;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] ARITH = 4'b0000, BRANCH = 4'b0110, JUMP = 4'b1001,
                         READ = 4'b1110, HALT = 4'b1111;

  issue_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .id_valid    (id_valid),
    .id_instr_op (id_instr_op),
    .id_areg     (id_areg),
    .id_breg     (id_breg),
    .id_dreg     (id_dreg),
    .id_ready    (id_ready),
    .ex_issue    (ex_issue),
    .mem_busy    (mem_busy),
    .br_resolved (br_resolved),
    .br_taken    (br_taken),
    .wb_valid    (wb_valid),
    .wb_dreg     (wb_dreg),
    .flush       (flush),
    .halted      (halted),
    .stall_cause (stall_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive ID inputs, then let combinational outputs settle before checking.
  task automatic drv(input logic v, input logic [3:0] op, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] d);
    id_valid = v; id_instr_op = op; id_areg = a; id_breg = b; id_dreg = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; id_valid = 1'b0; id_instr_op = '0; id_areg = '0;
    id_breg = '0; id_dreg = '0; mem_busy = 1'b0; br_resolved = 1'b0;
    br_taken = 1'b0; wb_valid = 1'b0; wb_dreg = '0;
    #2;
    chk("rst_ex_issue", {3'b0, ex_issue}, 4'd0);
    chk("rst_flush", {3'b0, flush}, 4'd0);
    chk("rst_halted", {3'b0, halted}, 4'd0);
    chk("rst_stall", {2'b0, stall_cause}, 4'd0);
    chk("rst_ready", {3'b0, id_ready}, 4'd1);
    #10 resetn = 1'b1;
    tick();

`ifndef ISSUE_FWD_EN
    // RAW: ARITH r3 then ARITH r5 = r3 + r1, writeback of r3 in cycle 4.
    drv(1, ARITH, 4'd1, 4'd2, 4'd3);
    chk("raw_c0_ready", {3'b0, id_ready}, 4'd1);
    chk("raw_c0_stall", {2'b0, stall_cause}, 4'd0);
    tick();
    drv(1, ARITH, 4'd3, 4'd1, 4'd5);
    chk("raw_c1_ex_issue", {3'b0, ex_issue}, 4'd1);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin wb_valid = 1'b1; wb_dreg = 4'd3; #1; end
      chk($sformatf("raw_c%0d_ready", c), {3'b0, id_ready}, 4'd0);
      chk($sformatf("raw_c%0d_stall", c), {2'b0, stall_cause}, 4'd1);
      tick();
      if (c == 1) chk("raw_c2_ex_issue", {3'b0, ex_issue}, 4'd0);
    end
    wb_valid = 1'b0; #1;
    chk("raw_c5_ready", {3'b0, id_ready}, 4'd1);
    chk("raw_c5_stall", {2'b0, stall_cause}, 4'd0);
    tick();
    chk("raw_c6_ex_issue", {3'b0, ex_issue}, 4'd1);
    // r5 now pending: hazard with id_valid low reports no stall cause.
    drv(0, ARITH, 4'd5, 4'd0, 4'd6);
    chk("raw_novalid_ready", {3'b0, id_ready}, 4'd0);
    chk("raw_novalid_stall", {2'b0, stall_cause}, 4'd0);
    wb_valid = 1'b1; wb_dreg = 4'd5;
    tick();
    wb_valid = 1'b0;
`endif

    // mem_busy blocks issue and leaves the scoreboard untouched.
    mem_busy = 1'b1;
    drv(1, ARITH, 4'd1, 4'd2, 4'd4);
    chk("mem_ready", {3'b0, id_ready}, 4'd0);
    chk("mem_stall", {2'b0, stall_cause}, 4'd3);
    tick();
    mem_busy = 1'b0;
    drv(0, ARITH, 4'd4, 4'd4, 4'd10);
    chk("mem_ex_issue", {3'b0, ex_issue}, 4'd0);
    chk("mem_sb_clean", {3'b0, id_ready}, 4'd1);

    // r0 destination and sources never stall.
    drv(1, ARITH, 4'd0, 4'd0, 4'd0);
    tick();
    drv(1, ARITH, 4'd0, 4'd0, 4'd0);
    chk("r0_ready", {3'b0, id_ready}, 4'd1);
    chk("r0_stall", {2'b0, stall_cause}, 4'd0);
    tick();
    chk("r0_ex_issue", {3'b0, ex_issue}, 4'd1);

    // Same-cycle READ r7 issue and writeback of r7: set wins.
    wb_valid = 1'b1; wb_dreg = 4'd7;
    drv(1, READ, 4'd1, 4'd2, 4'd7);
    chk("setclr_ready", {3'b0, id_ready}, 4'd1);
    tick();
    wb_valid = 1'b0;
    drv(1, ARITH, 4'd7, 4'd0, 4'd8);
    chk("setclr_dep_ready", {3'b0, id_ready}, 4'd0);
    chk("setclr_dep_stall", {2'b0, stall_cause}, 4'd1);
    drv(0, ARITH, 4'd0, 4'd0, 4'd0);
    wb_valid = 1'b1; wb_dreg = 4'd7;
    tick();
    wb_valid = 1'b0;

    // Taken branch resolved three cycles after issue.
    drv(1, BRANCH, 4'd1, 4'd2, 4'd0);
    chk("br_issue_ready", {3'b0, id_ready}, 4'd1);
    tick();
    drv(1, ARITH, 4'd1, 4'd2, 4'd9);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin br_resolved = 1'b1; br_taken = 1'b1; #1; end
      chk($sformatf("br_c%0d_ready", c), {3'b0, id_ready}, 4'd0);
      chk($sformatf("br_c%0d_stall", c), {2'b0, stall_cause}, 4'd2);
      chk($sformatf("br_c%0d_flush", c), {3'b0, flush}, (c == 3) ? 4'd1 : 4'd0);
      tick();
    end
    br_resolved = 1'b0; br_taken = 1'b0; #1;
    chk("br_c4_ready", {3'b0, id_ready}, 4'd1);
    chk("br_c4_flush", {3'b0, flush}, 4'd0);
    tick();
    // Resolve while in RUN is ignored.
    drv(0, ARITH, 4'd0, 4'd0, 4'd0);
    br_resolved = 1'b1; br_taken = 1'b1; #1;
    chk("br_run_noflush", {3'b0, flush}, 4'd0);
    tick();
    br_resolved = 1'b0; br_taken = 1'b0;
    // Not-taken jump resolved next cycle: no flush, issue resumes.
    drv(1, JUMP, 4'd0, 4'd0, 4'd0);
    tick();
    drv(1, ARITH, 4'd0, 4'd0, 4'd0);
    br_resolved = 1'b1; #1;
    chk("nt_flush", {3'b0, flush}, 4'd0);
    chk("nt_wait_ready", {3'b0, id_ready}, 4'd0);
    tick();
    br_resolved = 1'b0; #1;
    chk("nt_resume_ready", {3'b0, id_ready}, 4'd1);
    drv(0, ARITH, 4'd0, 4'd0, 4'd0);
    tick();

    // HALT is sticky until reset.
    drv(1, HALT, 4'd0, 4'd0, 4'd0);
    chk("halt_issue_ready", {3'b0, id_ready}, 4'd1);
    chk("halt_pre_halted", {3'b0, halted}, 4'd0);
    tick();
    chk("halt_ex_issue", {3'b0, ex_issue}, 4'd1);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("halt_c%0d_halted", c), {3'b0, halted}, 4'd1);
      chk($sformatf("halt_c%0d_ready", c), {3'b0, id_ready}, 4'd0);
      chk($sformatf("halt_c%0d_stall", c), {2'b0, stall_cause}, 4'd3);
      tick();
    end
    br_resolved = 1'b1; br_taken = 1'b1; #1;
    chk("halt_noflush", {3'b0, flush}, 4'd0);
    tick();
    br_resolved = 1'b0; br_taken = 1'b0;
    chk("halt_ex_idle", {3'b0, ex_issue}, 4'd0);

    // Asynchronous reset clears everything, including any pending r9.
    drv(0, ARITH, 4'd0, 4'd0, 4'd0);
    resetn = 1'b0; #1;
    chk("rst2_halted", {3'b0, halted}, 4'd0);
    chk("rst2_ex_issue", {3'b0, ex_issue}, 4'd0);
    chk("rst2_flush", {3'b0, flush}, 4'd0);
    chk("rst2_stall", {2'b0, stall_cause}, 4'd0);
    tick();
    resetn = 1'b1;
    drv(1, ARITH, 4'd9, 4'd9, 4'd9);
    chk("rst2_sb_clean", {3'b0, id_ready}, 4'd1);
    tick();
    drv(0, ARITH, 4'd0, 4'd0, 4'd0);
    wb_valid = 1'b1; wb_dreg = 4'd9;
    tick();
    wb_valid = 1'b0;

`ifdef ISSUE_FWD_EN
    // Forwarded ARITH result: dependent issues back-to-back.
    drv(1, ARITH, 4'd1, 4'd1, 4'd2);
    tick();
    drv(1, ARITH, 4'd2, 4'd0, 4'd3);
    chk("fwd_arith_ready", {3'b0, id_ready}, 4'd1);
    tick();
    // READ still tracked: dependent waits for writeback.
    drv(1, READ, 4'd1, 4'd1, 4'd2);
    tick();
    drv(1, ARITH, 4'd2, 4'd0, 4'd3);
    chk("fwd_read_ready", {3'b0, id_ready}, 4'd0);
    chk("fwd_read_stall", {2'b0, stall_cause}, 4'd1);
    wb_valid = 1'b1; wb_dreg = 4'd2;
    tick();
    wb_valid = 1'b0; #1;
    chk("fwd_read_resume", {3'b0, id_ready}, 4'd1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
